// File: rtl/memory_stage.sv
// Memory stage: data-memory load/store, stack push/pop and two-cycle CALL/RET PC transfer.
// Define STACK_GUARD_EN to add stack over/underflow protection with a sticky stack_fault.
module memory_stage #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] SP_RESET = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [15:0]       ex_alu_out,
    input  logic [15:0]       ex_mem_addr,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_push,
    input  logic              ex_pop,
    input  logic              ex_call,
    input  logic              ex_ret,
    input  logic [31:0]       ex_pc,
    input  logic [2:0]        ex_rdst,
    input  logic              ex_reg_write,
    output logic              stall_out,
    output logic              wb_valid,
    output logic [15:0]       wb_data,
    output logic [2:0]        wb_rdst,
    output logic              wb_reg_write,
    output logic              pc_load,
    output logic [31:0]       pc_value,
    output logic [ADDR_W-1:0] sp_out,
    output logic              stack_fault
);
    typedef enum logic {IDLE, SECOND} state_t;

    logic [15:0] mem [2**ADDR_W];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sp_q, sp_d, sp_inc, addr;
    logic [15:0]       pc_lo_q, pc_lo_d;
    logic              op_ret_q, op_ret_d;
    logic              wb_valid_d, wb_reg_write_d, pc_load_d;
    logic [15:0]       wb_data_d;
    logic [2:0]        wb_rdst_d;
    logic [31:0]       pc_value_d;
    logic              push_en, pop_en, st_en, stall;
    logic [15:0]       push_word, pop_word;
    logic              mem_we, fault_set, ovf, unf;
    logic [ADDR_W-1:0] mem_waddr;
    logic [15:0]       mem_wdata;
    logic              unused_bits;

    assign addr     = ex_mem_addr[ADDR_W-1:0];
    assign sp_inc   = sp_q + 1'b1;
    assign pop_word = unf ? 16'h0000 : mem[sp_inc];

`ifdef STACK_GUARD_EN
    logic fault_q;
    assign ovf         = (sp_q == '0);
    assign unf         = (sp_q == '1);
    assign stack_fault = fault_q;
    assign unused_bits = ^ex_mem_addr[15:ADDR_W];

    always_ff @(posedge clk) begin
        if (rst)            fault_q <= 1'b0;
        else if (fault_set) fault_q <= 1'b1;
    end
`else
    assign ovf         = 1'b0;
    assign unf         = 1'b0;
    assign stack_fault = 1'b0;
    assign unused_bits = ^{ex_mem_addr[15:ADDR_W], fault_set};
`endif

    always_comb begin
        state_d        = state_q;
        sp_d           = sp_q;
        pc_lo_d        = pc_lo_q;
        op_ret_d       = op_ret_q;
        wb_valid_d     = 1'b0;
        wb_data_d      = ex_alu_out;
        wb_rdst_d      = ex_rdst;
        wb_reg_write_d = 1'b0;
        pc_load_d      = 1'b0;
        pc_value_d     = pc_value;
        push_en        = 1'b0;
        push_word      = ex_alu_out;
        pop_en         = 1'b0;
        st_en          = 1'b0;
        stall          = 1'b0;
        unique case (state_q)
            IDLE: if (ex_valid) begin
                if (ex_ret) begin
                    pop_en   = 1'b1;
                    pc_lo_d  = pop_word;
                    op_ret_d = 1'b1;
                    stall    = 1'b1;
                    state_d  = SECOND;
                end else if (ex_call) begin
                    push_en   = 1'b1;
                    push_word = ex_pc[31:16];
                    pc_lo_d   = ex_pc[15:0];
                    op_ret_d  = 1'b0;
                    stall     = 1'b1;
                    state_d   = SECOND;
                end else begin
                    wb_valid_d     = 1'b1;
                    wb_reg_write_d = ex_reg_write;
                    if (ex_pop) begin
                        pop_en    = 1'b1;
                        wb_data_d = pop_word;
                    end else if (ex_push) begin
                        push_en = 1'b1;
                    end else if (ex_mem_write) begin
                        st_en = 1'b1;
                    end else if (ex_mem_read) begin
                        wb_data_d = mem[addr];
                    end
                end
            end
            SECOND: begin
                // pc_lo_q holds the CALL low half to push, or the RET low half already popped
                wb_valid_d = ex_valid;
                state_d    = IDLE;
                if (op_ret_q) begin
                    pop_en     = 1'b1;
                    pc_value_d = {pop_word, pc_lo_q};
                    pc_load_d  = 1'b1;
                end else begin
                    push_en   = 1'b1;
                    push_word = pc_lo_q;
                end
            end
            default: state_d = IDLE;
        endcase

        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = ex_alu_out;
        fault_set = 1'b0;
        if (push_en) begin
            if (ovf) begin
                fault_set = 1'b1;
            end else begin
                mem_we    = 1'b1;
                mem_waddr = sp_q;
                mem_wdata = push_word;
                sp_d      = sp_q - 1'b1;
            end
        end else if (st_en) begin
            mem_we = 1'b1;
        end
        if (pop_en) begin
            if (unf) fault_set = 1'b1;
            else     sp_d      = sp_inc;
        end
    end

    assign stall_out = stall & ~rst;
    assign sp_out    = sp_q;

    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sp_q         <= SP_RESET;
            pc_lo_q      <= '0;
            op_ret_q     <= 1'b0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rdst      <= '0;
            wb_reg_write <= 1'b0;
            pc_load      <= 1'b0;
            pc_value     <= '0;
        end else begin
            state_q      <= state_d;
            sp_q         <= sp_d;
            pc_lo_q      <= pc_lo_d;
            op_ret_q     <= op_ret_d;
            wb_valid     <= wb_valid_d;
            wb_data      <= wb_data_d;
            wb_rdst      <= wb_rdst_d;
            wb_reg_write <= wb_reg_write_d;
            pc_load      <= pc_load_d;
            pc_value     <= pc_value_d;
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: stimulus pushes expected write-back/PC results, a monitor pops them.
module tb_memory_stage;
    localparam int AW = 12;
    localparam logic [5:0] F_RD = 6'd1, F_WR = 6'd2, F_PUSH = 6'd4, F_POP = 6'd8,
                           F_CALL = 6'd16, F_RET = 6'd32;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_valid, ex_mem_read, ex_mem_write, ex_push, ex_pop, ex_call, ex_ret, ex_reg_write;
    logic [15:0]   ex_alu_out, ex_mem_addr;
    logic [31:0]   ex_pc;
    logic [2:0]    ex_rdst;
    logic          stall_out, wb_valid, wb_reg_write, pc_load, stack_fault;
    logic [15:0]   wb_data;
    logic [2:0]    wb_rdst;
    logic [31:0]   pc_value;
    logic [AW-1:0] sp_out;

    typedef struct packed {logic [15:0] d; logic [2:0] r; logic w;} exp_t;
    exp_t        expq[$];
    logic [31:0] pcq[$];
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    memory_stage #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
        .ex_mem_addr(ex_mem_addr), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_push(ex_push), .ex_pop(ex_pop), .ex_call(ex_call), .ex_ret(ex_ret), .ex_pc(ex_pc),
        .ex_rdst(ex_rdst), .ex_reg_write(ex_reg_write), .stall_out(stall_out),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rdst(wb_rdst), .wb_reg_write(wb_reg_write),
        .pc_load(pc_load), .pc_value(pc_value), .sp_out(sp_out), .stack_fault(stack_fault)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] f, input logic [15:0] alu,
                         input logic [15:0] a, input logic [31:0] pc, input logic [2:0] rd,
                         input logic rw);
        ex_valid = v;
        {ex_ret, ex_call, ex_pop, ex_push, ex_mem_write, ex_mem_read} = f;
        ex_alu_out = alu; ex_mem_addr = a; ex_pc = pc; ex_rdst = rd; ex_reg_write = rw;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic op1(input logic v, input logic [5:0] f, input logic [15:0] alu,
                       input logic [15:0] a, input logic [2:0] rd, input logic rw,
                       input logic [15:0] exp_d);
        drive(v, f, alu, a, 32'h0, rd, rw);
        if (v) expq.push_back({exp_d, rd, rw});
        tick();
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] p;
        if (wb_valid) begin
            if (expq.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
            else begin
                e = expq.pop_front();
                chk("wb_data", 32'(wb_data), 32'(e.d));
                chk("wb_rdst", 32'(wb_rdst), 32'(e.r));
                chk("wb_reg_write", 32'(wb_reg_write), 32'(e.w));
            end
        end
        if (pc_load) begin
            if (pcq.size() == 0) chk("pc_load_unexpected", 32'd1, 32'd0);
            else begin
                p = pcq.pop_front();
                chk("pc_value", pc_value, p);
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 6'd0, 16'h0, 16'h0, 32'h0, 3'd0, 1'b0);
        tick(); tick();
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", 32'(wb_data), 32'd0);
        chk("rst_pc_load", 32'(pc_load), 32'd0);
        chk("rst_pc_value", pc_value, 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_sp", 32'(sp_out), 32'h0FFF);
        chk("rst_fault", 32'(stack_fault), 32'd0);
        rst = 1'b0;

        // push then pop
        op1(1'b1, F_PUSH, 16'h1234, 16'h0, 3'd0, 1'b0, 16'h1234);
        chk("push_sp", 32'(sp_out), 32'h0FFE);
        op1(1'b1, F_POP, 16'h0, 16'h0, 3'd5, 1'b1, 16'h1234);
        chk("pop_sp", 32'(sp_out), 32'h0FFF);

        // store/load incl. aliasing via upper address bits
        op1(1'b1, F_WR, 16'hBEEF, 16'h0010, 3'd1, 1'b0, 16'hBEEF);
        op1(1'b1, F_RD, 16'h0, 16'h0010, 3'd2, 1'b1, 16'hBEEF);
        op1(1'b1, F_RD, 16'h0, 16'hF010, 3'd3, 1'b1, 16'hBEEF);

        // CALL: one stall cycle, then SECOND completes with no register write
        drive(1'b1, F_CALL, 16'h5555, 16'h0, 32'h0001_0200, 3'd4, 1'b1);
        #1 chk("call_stall_first", 32'(stall_out), 32'd1);
        tick();
        chk("call_stall_second", 32'(stall_out), 32'd0);
        expq.push_back({16'h5555, 3'd4, 1'b0});
        tick();
        chk("call_sp", 32'(sp_out), 32'h0FFD);
        op1(1'b1, F_RD, 16'h0, 16'h0FFF, 3'd1, 1'b1, 16'h0001);
        op1(1'b1, F_RD, 16'h0, 16'h0FFE, 3'd1, 1'b1, 16'h0200);

        // RET: pops low then high half, pulses pc_load
        drive(1'b1, F_RET, 16'h6666, 16'h0, 32'h0, 3'd6, 1'b1);
        #1 chk("ret_stall_first", 32'(stall_out), 32'd1);
        tick();
        chk("ret_stall_second", 32'(stall_out), 32'd0);
        expq.push_back({16'h6666, 3'd6, 1'b0});
        pcq.push_back(32'h0001_0200);
        tick();
        chk("ret_sp", 32'(sp_out), 32'h0FFF);
        chk("ret_pc_load", 32'(pc_load), 32'd1);

        // bubble with write flag must not store
        op1(1'b0, F_WR, 16'hDEAD, 16'h0010, 3'd0, 1'b1, 16'h0);
        op1(1'b1, F_RD, 16'h0, 16'h0010, 3'd2, 1'b1, 16'hBEEF);

        // reset during SECOND of a CALL
        drive(1'b1, F_CALL, 16'h0, 16'h0, 32'hAAAA_BBBB, 3'd0, 1'b0);
        tick();
        rst = 1'b1;
        drive(1'b0, 6'd0, 16'h0, 16'h0, 32'h0, 3'd0, 1'b0);
        tick();
        rst = 1'b0;
        chk("rst2_sp", 32'(sp_out), 32'h0FFF);
        chk("rst2_stall", 32'(stall_out), 32'd0);
        chk("rst2_pc_load", 32'(pc_load), 32'd0);
        op1(1'b1, F_PUSH, 16'h7777, 16'h0, 3'd0, 1'b0, 16'h7777);
        chk("rst2_push_sp", 32'(sp_out), 32'h0FFE);
        op1(1'b1, F_POP, 16'h0, 16'h0, 3'd2, 1'b1, 16'h7777);

        // push+pop together: pop only
        op1(1'b1, F_PUSH, 16'h1111, 16'h0, 3'd0, 1'b0, 16'h1111);
        op1(1'b1, F_PUSH | F_POP, 16'h9999, 16'h0, 3'd7, 1'b1, 16'h1111);
        chk("prio_sp", 32'(sp_out), 32'h0FFF);
        op1(1'b1, F_RD, 16'h0, 16'h0FFE, 3'd1, 1'b1, 16'h0200);

        op1(1'b1, F_WR, 16'h4242, 16'h0000, 3'd0, 1'b0, 16'h4242);
`ifndef STACK_GUARD_EN
        for (int i = 0; i < 4096; i++)
            op1(1'b1, F_PUSH, 16'(i), 16'h0, 3'd0, 1'b0, 16'(i));
        chk("wrap_sp", 32'(sp_out), 32'h0FFF);
        op1(1'b1, F_POP, 16'h0, 16'h0, 3'd3, 1'b1, 16'h0FFF);
        chk("wrap_pop_sp", 32'(sp_out), 32'h0000);
        chk("wrap_fault", 32'(stack_fault), 32'd0);
`else
        for (int i = 0; i < 4095; i++)
            op1(1'b1, F_PUSH, 16'(i), 16'h0, 3'd0, 1'b0, 16'(i));
        chk("guard_sp0", 32'(sp_out), 32'h0000);
        chk("guard_fault0", 32'(stack_fault), 32'd0);
        op1(1'b1, F_PUSH, 16'h9999, 16'h0, 3'd0, 1'b0, 16'h9999);
        chk("ovf_fault", 32'(stack_fault), 32'd1);
        chk("ovf_sp", 32'(sp_out), 32'h0000);
        op1(1'b1, F_RD, 16'h0, 16'h0000, 3'd1, 1'b1, 16'h4242);
        chk("ovf_sticky", 32'(stack_fault), 32'd1);
        rst = 1'b1;
        drive(1'b0, 6'd0, 16'h0, 16'h0, 32'h0, 3'd0, 1'b0);
        tick();
        rst = 1'b0;
        chk("guard_rst_fault", 32'(stack_fault), 32'd0);
        op1(1'b1, F_POP, 16'h0, 16'h0, 3'd3, 1'b1, 16'h0000);
        chk("unf_fault", 32'(stack_fault), 32'd1);
        chk("unf_sp", 32'(sp_out), 32'h0FFF);
`endif
        drive(1'b0, 6'd0, 16'h0, 16'h0, 32'h0, 3'd0, 1'b0);
        tick(); tick();
        chk("expq_drained", expq.size(), 32'd0);
        chk("pcq_drained", pcq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
